// File: rtl/sigma_delta_dac_gen.sv
// sigma_delta_dac_gen: run-time 1st/2nd-order sigma-delta DAC with saturating
// integrators, sticky overflow flag, valid/ready sample input and soft-mute ramp.
module sigma_delta_dac_gen #(
  parameter int WIDTH     = 16,
  parameter int GUARD     = 4,
  parameter int RAMP_STEP = 256
) (
  input  logic                    i_clk,
  input  logic                    i_res,
  input  logic                    i_ce,
  input  logic signed [WIDTH-1:0] i_sample,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_order,
  input  logic                    i_mute,
  output logic                    o_dac,
  output logic                    o_muted,
  output logic                    o_ovf
);
  localparam int AW = WIDTH + 1 + GUARD;
  localparam int SW = AW + 2;
  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] STEP = EW'(RAMP_STEP);
  localparam logic signed [SW-1:0] HALF = SW'(1) <<< (WIDTH - 1);
  localparam logic signed [SW-1:0] AMAX = (SW'(1) <<< (AW - 1)) - SW'(1);
  localparam logic signed [SW-1:0] AMIN = ~AMAX;

  typedef enum logic [1:0] {RUN, MUTING, MUTED, UNMUTING} state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, dac_q, dac_d, order_q, ovf_q, ovf_d, clip1, clip2;
  logic signed [WIDTH-1:0] sample_q, eff_q, eff_d, target, ramp;
  logic signed [EW-1:0]    diff;
  logic signed [AW-1:0]    acc1_q, acc1_d, acc2_q, acc2_d, a1, a2;
  logic signed [SW-1:0]    fb, s1, s2;

  // Ramp one step toward the target without overshoot.
  assign target = i_mute ? '0 : sample_q;
  assign diff   = EW'(target) - EW'(eff_q);
  assign ramp   = diff > STEP  ? WIDTH'(EW'(eff_q) + STEP) :
                  diff < -STEP ? WIDTH'(EW'(eff_q) - STEP) : target;

  always_ff @(posedge i_clk or posedge i_res)
    if (i_res) state_q <= RUN;
    else if (i_ce) state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      state_d = i_mute ? MUTING : RUN;
      MUTING:   state_d = !i_mute ? UNMUTING : ramp == '0 ? MUTED : MUTING;
      MUTED:    state_d = i_mute ? MUTED : UNMUTING;
      UNMUTING: state_d = i_mute ? MUTING : ramp == sample_q ? RUN : UNMUTING;
    endcase
  end

  always_comb begin
    eff_d = state_q == RUN ? sample_q : state_q == MUTED ? '0 : ramp;
  end

  assign o_muted = state_q == MUTED;

  // Sums carry two spare bits so neither stage can wrap before clamping.
  assign fb    = dac_q ? HALF : -HALF;
  assign s1    = SW'(acc1_q) + SW'(eff_d) - fb;
  assign clip1 = s1 > AMAX || s1 < AMIN;
  assign a1    = clip1 ? (s1[SW-1] ? AW'(AMIN) : AW'(AMAX)) : AW'(s1);
  assign s2    = SW'(acc2_q) + SW'(a1) - fb;
  assign clip2 = s2 > AMAX || s2 < AMIN;
  assign a2    = clip2 ? (s2[SW-1] ? AW'(AMIN) : AW'(AMAX)) : AW'(s2);

  // An order change spends its tick flushing both integrators.
  always_comb begin
    acc1_d = '0;
    acc2_d = '0;
    dac_d  = 1'b0;
    ovf_d  = ovf_q;
    if (i_order == order_q) begin
      acc1_d = a1;
      acc2_d = order_q ? a2 : acc2_q;
      dac_d  = order_q ? !a2[AW-1] : !a1[AW-1];
      ovf_d  = ovf_q | clip1 | (order_q & clip2);
    end
  end

  always_ff @(posedge i_clk or posedge i_res)
    if (i_res) begin
      ready_q  <= 1'b0;
      sample_q <= '0;
      eff_q    <= '0;
      acc1_q   <= '0;
      acc2_q   <= '0;
      dac_q    <= 1'b0;
      order_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (i_valid && ready_q) sample_q <= i_sample;
      if (i_ce) begin
        eff_q   <= eff_d;
        acc1_q  <= acc1_d;
        acc2_q  <= acc2_d;
        dac_q   <= dac_d;
        order_q <= i_order;
        ovf_q   <= ovf_d;
      end
    end

  assign o_ready = ready_q;
  assign o_dac   = dac_q;
  assign o_ovf   = ovf_q;
endmodule

// File: tb/tb_sigma_delta_dac_gen.sv
// tb_sigma_delta_dac_gen: directed bench with a saturating reference model and
// an expected-output queue for the sigma-delta DAC (WIDTH=16, GUARD=1, step 1024).
module tb_sigma_delta_dac_gen;
  localparam int    W    = 16;
  localparam int    RS   = 1024;
  localparam longint HALF = 32768;
  localparam longint AMAX = 131071;
  localparam longint AMIN = -131072;

  typedef struct {
    bit dac;
    bit muted;
    bit ovf;
    bit ready;
  } exp_t;

  logic i_clk = 1'b0, i_res, i_ce, i_valid, i_order, i_mute;
  logic signed [W-1:0] i_sample;
  logic o_ready, o_dac, o_muted, o_ovf;

  exp_t   exp_q[$];
  longint m_acc1, m_acc2, m_eff, m_sample;
  bit     m_dac, m_order, m_ovf, m_ready, chk_acc, last_dac;
  int     m_st, n_cmp = 0, n_bad = 0, ones, run_len, max_run;

  sigma_delta_dac_gen #(.WIDTH(W), .GUARD(1), .RAMP_STEP(RS)) dut (
    .i_clk(i_clk), .i_res(i_res), .i_ce(i_ce), .i_sample(i_sample),
    .i_valid(i_valid), .o_ready(o_ready), .i_order(i_order), .i_mute(i_mute),
    .o_dac(o_dac), .o_muted(o_muted), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint approach(input longint e, input longint t);
    if (t > e) return (e + RS > t) ? t : e + RS;
    return (e - RS < t) ? t : e - RS;
  endfunction

  function automatic longint clampv(input longint s);
    return s > AMAX ? AMAX : s < AMIN ? AMIN : s;
  endfunction

  task automatic model_reset();
    m_acc1 = 0; m_acc2 = 0; m_eff = 0; m_sample = 0;
    m_dac = 0; m_order = 0; m_ovf = 0; m_ready = 0; m_st = 0;
    exp_q.delete();
  endtask

  task automatic model_tick();
    longint fb, s, tgt;
    tgt = i_mute ? 0 : m_sample;
    case (m_st)
      0: begin m_eff = m_sample; if (i_mute) m_st = 1; end
      1: begin m_eff = approach(m_eff, tgt); if (!i_mute) m_st = 3; else if (m_eff == 0) m_st = 2; end
      2: begin m_eff = 0; if (!i_mute) m_st = 3; end
      default: begin m_eff = approach(m_eff, tgt); if (i_mute) m_st = 1; else if (m_eff == m_sample) m_st = 0; end
    endcase
    fb = m_dac ? HALF : -HALF;
    if (i_order != m_order) begin
      m_acc1 = 0; m_acc2 = 0; m_dac = 0;
    end else begin
      s = m_acc1 + m_eff - fb;
      if (s != clampv(s)) m_ovf = 1;
      m_acc1 = clampv(s);
      if (m_order) begin
        s = m_acc2 + m_acc1 - fb;
        if (s != clampv(s)) m_ovf = 1;
        m_acc2 = clampv(s);
        m_dac = m_acc2 >= 0;
      end else m_dac = m_acc1 >= 0;
    end
    m_order = i_order;
  endtask

  // One clock; o_dac is counted just before each tick for density checks.
  task automatic step(input bit ce);
    exp_t e;
    i_ce = ce;
    if (ce) ones += int'(o_dac);
    @(posedge i_clk);
    if (ce) model_tick();
    if (m_ready && i_valid) m_sample = longint'(i_sample);
    m_ready = 1;
    exp_q.push_back('{dac: m_dac, muted: (m_st == 2), ovf: m_ovf, ready: m_ready});
    #1;
    e = exp_q.pop_front();
    check("o_dac", o_dac, e.dac);
    check("o_muted", o_muted, e.muted);
    check("o_ovf", o_ovf, e.ovf);
    check("o_ready", o_ready, e.ready);
    check("eff", longint'(dut.eff_q), m_eff);
    if (chk_acc) begin
      check("acc1", longint'(dut.acc1_q), m_acc1);
      check("acc2", longint'(dut.acc2_q), m_acc2);
    end
    if (ce) begin
      run_len = (o_dac == last_dac) ? run_len + 1 : 1;
      last_dac = o_dac;
      if (run_len > max_run) max_run = run_len;
    end
    @(negedge i_clk);
  endtask

  task automatic tick(input int rate);
    repeat (rate - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic do_reset();
    i_res = 1'b1;
    model_reset();
    #1;
    check("rst_dac", o_dac, 0);
    check("rst_ready", o_ready, 0);
    check("rst_muted", o_muted, 0);
    check("rst_ovf", o_ovf, 0);
    @(negedge i_clk);
    i_res = 1'b0;
    #1;
    check("rel_ready", o_ready, 0);
    step(1'b0);
    step(1'b0);
    ones = 0; run_len = 1; max_run = 0; last_dac = o_dac;
  endtask

  task automatic run_mute(input int rate);
    int cnt;
    i_sample = 16384; i_mute = 1'b0;
    repeat (2) tick(rate);
    check("run_eff", longint'(dut.eff_q), 16384);
    i_mute = 1'b1;
    tick(rate);
    cnt = 0;
    while (!o_muted && cnt < 40) begin tick(rate); cnt++; end
    check("mute_ticks", cnt, 16);
    check("muted_eff", longint'(dut.eff_q), 0);
    i_mute = 1'b0;
    tick(rate);
    check("unmute_drop", o_muted, 0);
    cnt = 0;
    while (int'(dut.state_q) != 0 && cnt < 40) begin tick(rate); cnt++; end
    check("unmute_ticks", cnt, 16);
    check("unmute_eff", longint'(dut.eff_q), 16384);
  endtask

  initial begin
    i_res = 1'b0; i_ce = 1'b0; i_valid = 1'b1; i_order = 1'b0; i_mute = 1'b0;
    i_sample = '0; chk_acc = 1'b0;
    @(negedge i_clk);
    do_reset();
    repeat (64) step(1'b1);
    check("dens_zero", (ones >= 31 && ones <= 33), 1);
    check("zero_no_ovf", o_ovf, 0);

    i_sample = 16384;
    do_reset();
    repeat (256) step(1'b1);
    check("dens_o1_pos", (ones >= 191 && ones <= 193), 1);
    check("max_run_o1", (max_run <= 4), 1);

    i_sample = -16384; i_order = 1'b1;
    do_reset();
    step(1'b1);
    ones = 0;
    repeat (256) step(1'b1);
    check("dens_o2_neg", (ones >= 63 && ones <= 65), 1);

    i_sample = 8000;
    repeat (64) step(1'b1);
    i_order = 1'b0;
    chk_acc = 1'b1;
    step(1'b1);
    check("toggle_acc1", longint'(dut.acc1_q), 0);
    check("toggle_acc2", longint'(dut.acc2_q), 0);
    check("toggle_dac", o_dac, 0);
    ones = 0;
    repeat (256) step(1'b1);
    check("dens_o1_8000", (ones >= 158 && ones <= 160), 1);

    run_mute(1);
    run_mute(4);

    i_sample = 32767; i_order = 1'b1;
    do_reset();
    repeat (100) step(1'b1);
    i_sample = -32768;
    repeat (200) step(1'b1);
    check("ovf_set", o_ovf, 1);
    i_sample = 0;
    repeat (50) step(1'b1);
    check("ovf_sticky", o_ovf, 1);
    chk_acc = 1'b0;

    i_order = 1'b0; i_sample = 16384; i_mute = 1'b0;
    repeat (2) step(1'b1);
    i_mute = 1'b1;
    repeat (20) step(1'b1);
    i_mute = 1'b0;
    repeat (5) step(1'b1);
    check("pre_unmuting", int'(dut.state_q), 3);
    #2;
    i_res = 1'b1;
    model_reset();
    #1;
    check("async_dac", o_dac, 0);
    check("async_ready", o_ready, 0);
    check("async_muted", o_muted, 0);
    check("async_ovf", o_ovf, 0);
    @(negedge i_clk);
    #1;
    check("hold_ready", o_ready, 0);
    @(negedge i_clk);
    i_res = 1'b0; i_sample = 1234;
    #1;
    check("post_rel_ready", o_ready, 0);
    step(1'b0);
    check("ready_up", o_ready, 1);
    check("no_early_load", longint'(dut.sample_q), 0);
    step(1'b0);
    check("new_sample", longint'(dut.sample_q), 1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sigma_delta_dac_gen.md
Name: sigma_delta_dac_gen

Overview:
Parametrised successor to the team's first-order sigma-delta DAC. It has run-time selectable 1st/2nd-order noise shaping, configurable input width and integrator guard bits, and saturating integrators with a sticky overflow flag. It also adds a valid/ready sample input and a click-free soft-mute ramp state machine. It sits between the audio/function sample source and the 1-bit output pin, and is clocked by the fast DAC clock with i_ce as the modulator tick.

Parameters:
WIDTH, 16, signed two's-complement input sample width (>=4)
GUARD, 4, extra integrator bits above WIDTH+1 (>=1); integrator width AW = WIDTH+1+GUARD
RAMP_STEP, 256, per-tick mute/unmute ramp increment, in sample LSBs (>=1, < 2^(WIDTH-1))

Ports:
i_clk  in  1  clock
i_res  in  1  asynchronous, active-high reset
i_ce  in  1  modulator tick enable; all state except the input register advances only when high
i_sample  in  WIDTH  signed input sample
i_valid  in  1  i_sample valid
o_ready  out  1  block accepts sample
i_order  in  1  0 = first order, 1 = second order
i_mute  in  1  request soft mute
o_dac  out  1  registered 1-bit DAC output
o_muted  out  1  high while fully muted
o_ovf  out  1  sticky integrator saturation flag

Behaviour:
- Reset (async, i_res=1): o_dac=0, o_ready=0, o_muted=0, o_ovf=0. Sample reg, eff value, acc1, acc2 = 0. order_q=0. State=RUN.
- o_ready: 0 during reset and the first i_clk after release, then constantly 1. Sample reg loads on any clock with i_valid & o_ready, independent of i_ce.
- Feedback fb = o_dac ? +2^(WIDTH-1) : -2^(WIDTH-1). eff is sign-extended to AW.
- Each i_ce tick:
  - order 1: acc1 <= sat(acc1 + eff - fb); o_dac <= (new acc1 >= 0).
  - order 2: acc1 <= sat(acc1 + eff - fb); acc2 <= sat(acc2 + new acc1 - fb); o_dac <= (new acc2 >= 0).
  - Compute sums at AW+1 bits. sat() clamps to [-2^(AW-1), 2^(AW-1)-1]. Any clamp sets o_ovf; only reset clears it.
- Order change: order_q samples i_order on each tick. If i_order != order_q, that tick zeroes acc1 and acc2 instead of integrating, and o_dac <= 0. Normal operation resumes on the next tick.
- Latency: a sample accepted before a tick is used at that tick (RUN state); o_dac reflects it 1 clock after the tick.
- Mute FSM, evaluated only on ticks; target = i_mute ? 0 : sample:
  - RUN: eff <= sample. If i_mute, go to MUTING.
  - MUTING: eff moves toward 0 by RAMP_STEP, clamped at 0, with no overshoot. When eff reaches 0, go to MUTED. If i_mute drops, go to UNMUTING.
  - MUTED: eff=0, o_muted=1. If !i_mute, go to UNMUTING and drop o_muted on the same tick.
  - UNMUTING: eff moves toward the current sample by RAMP_STEP, clamped at target. When eff == sample, go to RUN. If i_mute, go to MUTING.
  - A sample change during ramping retargets the ramp and causes no jump.
- i_ce low: acc1, acc2, o_dac, eff and the FSM all hold.
- Full-scale input -2^(WIDTH-1) is legal. +2^(WIDTH-1)-1 is the maximum.
- Reset mid-ramp or mid-overflow returns to the reset values immediately.

Test Plan:
- WIDTH=16, order 1, sample 0, i_ce every clock, 64 ticks -> 32±1 ones; o_ovf stays 0.
- Order 1, sample +16384, 256 ticks -> 192±1 ones; order 2, sample -16384, 256 ticks -> 64±1 ones; no run of more than 4 identical bits in order 1.
- Order 2 at sample 8000, toggle i_order to 0 -> on the toggle tick acc1=acc2=0 and o_dac=0; the next 256 ticks give the order-1 density for 8000 (±1).
- RAMP_STEP=1024, sample 16384, assert i_mute -> eff reaches 0 after exactly 16 ticks and o_muted rises then. Deassert -> o_muted falls on the next tick; RUN is re-entered 16 ticks later. Repeat with i_ce at 1/4 rate -> same tick counts.
- GUARD=1, order 2, sample 32767, then step to -32768 -> o_ovf sets and stays set; acc never wraps sign (checker compares against a saturating model).
- Assert i_res mid-UNMUTING with i_valid high -> all outputs 0 asynchronously; o_ready low for reset plus 1 clock, then high and accepts a new sample.
